// File: rtl/irq_pkg.sv
// Shared register map and field constants for the interrupt controller.
package irq_pkg;

  localparam logic [1:0] IRQ_PENDING = 2'd0;
  localparam logic [1:0] IRQ_ENABLE  = 2'd1;
  localparam logic [1:0] IRQ_EDGE    = 2'd2;
  localparam logic [1:0] IRQ_CAUSE   = 2'd3;

  localparam int VALID_BIT = 31;
  localparam int INDEX_W   = 5;
  localparam int NSRC_MAX  = 31;

  // Expand the 4-bit byte write mask into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    lane_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side register bus of the interrupt controller.
interface irq_controller_if;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  we;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, rd, wdata, input rdata);
  modport slave  (input sel, addr, we, rd, wdata, output rdata);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NSRC = 3
) (
  input  logic [NSRC-1:0]    in,
  output logic               valid,
  output logic [INDEX_W-1:0] index
);

  // Scan downwards so the last hit, which is kept, is the lowest set index.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (in[i]) begin
        valid = 1'b1;
        index = INDEX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches source events, masks them and
// presents the highest-priority pending source through a claim-on-read CAUSE.
module irq_controller
  import irq_pkg::*;
#(
  parameter int              NSRC         = 3,
  parameter logic [NSRC-1:0] RESET_ENABLE = '0
) (
  input  logic            clk,
  input  logic            reset,
  irq_controller_if.slave bus,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  logic [NSRC-1:0]    src_prev;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    enable;
  logic [NSRC-1:0]    edge_q;
  logic [31:0]        rdata_q;

  logic [31:0]        lanes;
  logic [31:0]        wr_bits;
  logic [NSRC-1:0]    wr_lanes;
  logic [NSRC-1:0]    wr_vals;
  logic               wr_en;
  logic               rd_en;
  logic [NSRC-1:0]    active;
  logic               win_valid;
  logic [INDEX_W-1:0] win_idx;
  logic [NSRC-1:0]    w1c;
  logic [NSRC-1:0]    claim;
  logic [NSRC-1:0]    rise;
  logic [NSRC-1:0]    pending_next;
  logic [31:0]        rd_val;
  logic               unused_hi;

  assign lanes    = lane_mask(bus.we);
  assign wr_bits  = bus.wdata & lanes;
  assign wr_lanes = lanes[NSRC-1:0];
  assign wr_vals  = wr_bits[NSRC-1:0];
  assign wr_en    = bus.sel & (|bus.we);
  assign rd_en    = bus.sel & bus.rd;
  assign active   = pending & enable;
  assign unused_hi = &{1'b0, lanes[31:NSRC], wr_bits[31:NSRC]};

  irq_prio_enc #(.NSRC(NSRC)) u_prio (
    .in    (active),
    .valid (win_valid),
    .index (win_idx)
  );

  // Edge bits: set wins over W1C/claim so a coincident event is never lost.
  // Level bits simply track the source line.
  always_comb begin
    w1c   = '0;
    claim = '0;
    if (wr_en && bus.addr == IRQ_PENDING) w1c = wr_vals;
    if (rd_en && bus.addr == IRQ_CAUSE && win_valid) claim = NSRC'(1) << win_idx;
    rise         = src & ~src_prev;
    pending_next = (edge_q & ((pending & ~(w1c | claim)) | rise)) | (~edge_q & src);
  end

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      IRQ_PENDING: rd_val[NSRC-1:0] = pending;
      IRQ_ENABLE:  rd_val[NSRC-1:0] = enable;
      IRQ_EDGE:    rd_val[NSRC-1:0] = edge_q;
      default: begin
        rd_val[VALID_BIT]     = win_valid;
        rd_val[INDEX_W-1:0]   = win_idx;
      end
    endcase
  end

  // Register stage: state, read data and registered irq all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_prev <= '0;
      pending  <= '0;
      enable   <= RESET_ENABLE;
      edge_q   <= '0;
      rdata_q  <= '0;
      irq      <= 1'b0;
    end else begin
      src_prev <= src;
      pending  <= pending_next;
      irq      <= |active;
      if (wr_en && bus.addr == IRQ_ENABLE)
        enable <= (enable & ~wr_lanes) | wr_vals;
      if (wr_en && bus.addr == IRQ_EDGE)
        edge_q <= (edge_q & ~wr_lanes) | wr_vals;
      if (rd_en)
        rdata_q <= rd_val;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; read results are checked via a scoreboard queue.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int              NSRC   = 3;
  localparam logic [NSRC-1:0] RST_EN = 3'b101;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            irq;

  irq_controller_if bus ();

  irq_controller #(.NSRC(NSRC), .RESET_ENABLE(RST_EN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] we = 4'hf);
    bus.sel   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
    step();
    bus.sel   = 1'b0;
    bus.we    = 4'h0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    bus.sel  = 1'b1;
    bus.rd   = 1'b1;
    bus.addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    step();
    bus.sel = 1'b0;
    bus.rd  = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.rdata, e);
    end
  endtask

  initial begin
    bus.sel = 1'b0; bus.rd = 1'b0; bus.we = 4'h0; bus.addr = 2'd0; bus.wdata = '0;
    src = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // T1 reset values
    check("t1_irq", {31'd0, irq}, 32'd0);
    rd(IRQ_PENDING, 32'h0, "t1_pending");
    rd(IRQ_ENABLE,  32'h5, "t1_enable");
    rd(IRQ_EDGE,    32'h0, "t1_edge");
    rd(IRQ_CAUSE,   32'h0, "t1_cause");
    check("t1_irq_end", {31'd0, irq}, 32'd0);

    // T2 single edge event and claim
    wr(IRQ_EDGE, 32'h7);
    wr(IRQ_ENABLE, 32'h7);
    src = 3'b010; step(); src = '0;
    check("t2_irq_lag", {31'd0, irq}, 32'd0);
    step();
    check("t2_irq_set", {31'd0, irq}, 32'd1);
    rd(IRQ_PENDING, 32'h2, "t2_pending");
    rd(IRQ_CAUSE, 32'h8000_0001, "t2_cause");
    bus.rd = 1'b1; bus.addr = IRQ_PENDING; step(); bus.rd = 1'b0;
    check("t2_rd_nosel_hold", bus.rdata, 32'h8000_0001);
    check("t2_irq_clr", {31'd0, irq}, 32'd0);
    rd(IRQ_PENDING, 32'h0, "t2_pending_clr");

    // T3 priority between two simultaneous events
    src = 3'b110; step(); src = '0; step();
    check("t3_irq", {31'd0, irq}, 32'd1);
    rd(IRQ_CAUSE, 32'h8000_0001, "t3_cause1");
    rd(IRQ_CAUSE, 32'h8000_0002, "t3_cause2");
    check("t3_irq_still", {31'd0, irq}, 32'd1);
    rd(IRQ_CAUSE, 32'h0, "t3_cause_none");
    check("t3_irq_drop", {31'd0, irq}, 32'd0);

    // T4 edge and W1C in the same cycle
    bus.sel = 1'b1; bus.we = 4'hf; bus.addr = IRQ_PENDING; bus.wdata = 32'h1;
    src = 3'b001;
    step();
    bus.sel = 1'b0; bus.we = 4'h0; src = '0;
    rd(IRQ_PENDING, 32'h1, "t4_set_wins");
    wr(IRQ_PENDING, 32'h1);
    rd(IRQ_PENDING, 32'h0, "t4_w1c");

    // Byte lanes and unimplemented bits
    wr(IRQ_ENABLE, 32'h0);
    wr(IRQ_ENABLE, 32'hffff_ffff, 4'b1110);
    rd(IRQ_ENABLE, 32'h0, "lane_masked");
    wr(IRQ_ENABLE, 32'hffff_ffff, 4'b0001);
    rd(IRQ_ENABLE, 32'h7, "lane0_upper_zero");

    // T5 level mode
    wr(IRQ_EDGE, 32'h0);
    src = 3'b001; step();
    rd(IRQ_CAUSE, 32'h8000_0000, "t5_cause1");
    rd(IRQ_CAUSE, 32'h8000_0000, "t5_cause2");
    wr(IRQ_PENDING, 32'h1);
    rd(IRQ_PENDING, 32'h1, "t5_w1c_noeffect");
    src = '0; step(); step();
    check("t5_irq_drop", {31'd0, irq}, 32'd0);
    rd(IRQ_PENDING, 32'h0, "t5_pending_drop");

    // T6 masking, then reset mid-operation
    wr(IRQ_EDGE, 32'h7);
    wr(IRQ_ENABLE, 32'h0);
    src = 3'b001; step(); src = '0; step(); step();
    check("t6_irq_masked", {31'd0, irq}, 32'd0);
    rd(IRQ_CAUSE, 32'h0, "t6_cause_masked");
    rd(IRQ_PENDING, 32'h1, "t6_pending_kept");
    wr(IRQ_ENABLE, 32'h1);
    step();
    check("t6_irq_unmasked", {31'd0, irq}, 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_irq_reset", {31'd0, irq}, 32'd0);
    rd(IRQ_PENDING, 32'h0, "t6_pending_reset");
    rd(IRQ_ENABLE, 32'h5, "t6_enable_reset");
    rd(IRQ_EDGE, 32'h0, "t6_edge_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
